// File: rtl/akuma_move_ctrl_if.sv
// Control/pose bundle between the player-input side and the Akuma movement controller.
// The master drives the frame strobe and controls; the slave (the controller) drives sprite, position and hitbox flag.
interface akuma_move_ctrl_if;
    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       key_down;
    logic       key_punch;
    logic       dead;
    logic [2:0] sprite;
    logic [9:0] AkumaX;
    logic [9:0] AkumaY;
    logic       attack_active;

    modport master (
        output frame_tick, key_left, key_right, key_up, key_down, key_punch, dead,
        input  sprite, AkumaX, AkumaY, attack_active
    );

    modport slave (
        input  frame_tick, key_left, key_right, key_up, key_down, key_punch, dead,
        output sprite, AkumaX, AkumaY, attack_active
    );
endinterface

// File: rtl/akuma_move_ctrl.sv
// Akuma frame-rate movement/animation controller: state machine, walking, jump physics and attack windows.
// Every update happens on a frame_tick cycle; outputs are registered and held between ticks.
module akuma_move_ctrl #(
    parameter int X_INIT       = 100,
    parameter int GROUND_Y     = 300,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 560,
    parameter int WALK_STEP    = 2,
    parameter int JUMP_V0      = 12,
    parameter int PUNCH_FRAMES = 12
) (
    input  logic              vga_clk,
    input  logic              Reset,
    akuma_move_ctrl_if.slave  bus
);

    // State encoding doubles as the sprite select code.
    typedef enum logic [2:0] {
        STAND    = 3'd0,
        PUNCH    = 3'd1,
        JUMP     = 3'd2,
        CROUCH   = 3'd3,
        WALK_L   = 3'd4,
        WALK_R   = 3'd5,
        DEATH    = 3'd6,
        JUMP_ATK = 3'd7
    } state_t;

    localparam logic [9:0]         X_INIT_X  = 10'(X_INIT);
    localparam logic [9:0]         GROUND_X  = 10'(GROUND_Y);
    localparam logic [9:0]         X_MIN_X   = 10'(X_MIN);
    localparam logic [9:0]         X_MAX_X   = 10'(X_MAX);
    localparam logic [9:0]         STEP_X    = 10'(WALK_STEP);
    localparam logic [10:0]        X_MIN_W   = 11'(X_MIN);
    localparam logic [10:0]        X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0]        STEP_W    = 11'(WALK_STEP);
    localparam logic signed [10:0] GROUND_S  = 11'(GROUND_Y);
    localparam logic signed [5:0]  V0_S      = 6'(JUMP_V0);
    localparam logic [7:0]         PUNCH_CNT = 8'(PUNCH_FRAMES);

    state_t             state_reg;
    logic [9:0]         x_reg;
    logic [9:0]         y_reg;
    logic signed [5:0]  vy_reg;
    logic [7:0]         cnt_reg;
    logic               punch_prev_reg;
    logic               attack_reg;

    logic               punch_evt;
    logic               go_left;
    logic               go_right;
    logic               in_air;
    logic [10:0]        x_ext;
    logic [9:0]         x_left;
    logic [9:0]         x_right;
    logic [9:0]         x_drift;
    logic [9:0]         y_src;
    logic signed [5:0]  vy_src;
    logic signed [10:0] vy_ext;
    logic signed [10:0] y_next_s;
    logic signed [5:0]  vy_dec;
    logic               landed;

    always_comb begin
        punch_evt = bus.key_punch & ~punch_prev_reg;
        go_left   = bus.key_left & ~bus.key_right;
        go_right  = bus.key_right & ~bus.key_left;
        in_air    = (state_reg == JUMP) || (state_reg == JUMP_ATK);

        // Clamp in 11 bits so stepping below X_MIN or above X_MAX never wraps.
        x_ext   = {1'b0, x_reg};
        x_left  = (x_ext >= X_MIN_W + STEP_W) ? (x_reg - STEP_X) : X_MIN_X;
        x_right = (x_ext + STEP_W > X_MAX_W)  ? X_MAX_X : (x_reg + STEP_X);
        x_drift = go_left ? x_left : (go_right ? x_right : x_reg);

        // On take-off the first physics step runs from the ground with the launch velocity.
        y_src    = in_air ? y_reg  : GROUND_X;
        vy_src   = in_air ? vy_reg : V0_S;
        vy_ext   = {{5{vy_src[5]}}, vy_src};
        y_next_s = $signed({1'b0, y_src}) - vy_ext;
        vy_dec   = vy_src - 6'sd1;
        landed   = (y_next_s >= GROUND_S);
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= STAND;
            x_reg          <= X_INIT_X;
            y_reg          <= GROUND_X;
            vy_reg         <= '0;
            cnt_reg        <= '0;
            punch_prev_reg <= 1'b0;
            attack_reg     <= 1'b0;
        end else if (bus.frame_tick) begin
            punch_prev_reg <= bus.key_punch;
            if (state_reg != DEATH) begin
                if (bus.dead) begin
                    state_reg  <= DEATH;
                    attack_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        STAND, WALK_L, WALK_R, CROUCH: begin
                            if (punch_evt) begin
                                state_reg  <= PUNCH;
                                cnt_reg    <= PUNCH_CNT;
                                attack_reg <= 1'b1;
                            end else if (bus.key_up) begin
                                x_reg <= x_drift;
                                if (landed) begin
                                    state_reg <= STAND;
                                    y_reg     <= GROUND_X;
                                    vy_reg    <= '0;
                                end else begin
                                    state_reg <= JUMP;
                                    y_reg     <= y_next_s[9:0];
                                    vy_reg    <= vy_dec;
                                end
                            end else if (bus.key_down) begin
                                state_reg <= CROUCH;
                            end else if (go_left) begin
                                state_reg <= WALK_L;
                                x_reg     <= x_left;
                            end else if (go_right) begin
                                state_reg <= WALK_R;
                                x_reg     <= x_right;
                            end else begin
                                state_reg <= STAND;
                            end
                        end
                        PUNCH: begin
                            if (cnt_reg <= 8'd1) begin
                                state_reg  <= STAND;
                                cnt_reg    <= '0;
                                attack_reg <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_reg - 8'd1;
                            end
                        end
                        JUMP, JUMP_ATK: begin
                            x_reg <= x_drift;
                            // Touching ground ends the jump even if an air attack is still running.
                            if (landed) begin
                                state_reg  <= STAND;
                                y_reg      <= GROUND_X;
                                vy_reg     <= '0;
                                cnt_reg    <= '0;
                                attack_reg <= 1'b0;
                            end else begin
                                y_reg  <= y_next_s[9:0];
                                vy_reg <= vy_dec;
                                if (state_reg == JUMP && punch_evt) begin
                                    state_reg  <= JUMP_ATK;
                                    cnt_reg    <= PUNCH_CNT;
                                    attack_reg <= 1'b1;
                                end else if (state_reg == JUMP_ATK) begin
                                    if (cnt_reg <= 8'd1) begin
                                        state_reg  <= JUMP;
                                        cnt_reg    <= '0;
                                        attack_reg <= 1'b0;
                                    end else begin
                                        cnt_reg <= cnt_reg - 8'd1;
                                    end
                                end
                            end
                        end
                        DEATH: begin
                        end
                        default: begin
                            state_reg <= STAND;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.sprite        = state_reg;
    assign bus.AkumaX        = x_reg;
    assign bus.AkumaY        = y_reg;
    assign bus.attack_active = attack_reg;

endmodule

// File: tb/tb_akuma_move_ctrl.sv
// Scoreboard bench for akuma_move_ctrl: stimulus pushes model predictions per frame tick,
// a monitor pops and compares after each tick, plus directed boundary checks.
module tb_akuma_move_ctrl;

    localparam int S_STAND = 0, S_PUNCH = 1, S_JUMP = 2, S_CROUCH = 3;
    localparam int S_WALK_L = 4, S_WALK_R = 5, S_DEATH = 6, S_JUMP_ATK = 7;
    localparam int G_Y = 300, V0 = 12, NPUNCH = 12, XMAX = 560;

    typedef struct {
        int sprite;
        int x;
        int y;
        int atk;
    } exp_t;

    logic vga_clk = 1'b0;
    logic Reset;
    akuma_move_ctrl_if bus();

    akuma_move_ctrl dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_ticks  = 0;
    exp_t q[$];

    // Reference model: position/height from take-off tick count, timers as remaining frames.
    int m_state, m_x, m_y, m_left, m_air;
    bit m_pprev;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = S_STAND; m_x = 100; m_y = G_Y; m_left = 0; m_air = 0; m_pprev = 0;
    endfunction

    function automatic int drift(bit l, bit r, int x);
        if (l && !r) return (x - 2 < 0) ? 0 : x - 2;
        if (r && !l) return (x + 2 > XMAX) ? XMAX : x + 2;
        return x;
    endfunction

    function automatic void air_step(bit l, bit r, bit evt);
        int rise;
        m_air++;
        rise = m_air * V0 - (m_air * (m_air - 1)) / 2;
        m_x = drift(l, r, m_x);
        if (rise <= 0) begin
            m_state = S_STAND; m_y = G_Y; m_left = 0;
            return;
        end
        m_y = G_Y - rise;
        if (m_state == S_JUMP && evt) begin
            m_state = S_JUMP_ATK; m_left = NPUNCH;
        end else if (m_state == S_JUMP_ATK) begin
            m_left--;
            if (m_left == 0) m_state = S_JUMP;
        end
    endfunction

    function automatic void model_step(bit l, bit r, bit u, bit d, bit p, bit dd);
        bit evt;
        evt = p && !m_pprev;
        m_pprev = p;
        if (m_state == S_DEATH) return;
        if (dd) begin
            m_state = S_DEATH;
            return;
        end
        case (m_state)
            S_STAND, S_WALK_L, S_WALK_R, S_CROUCH: begin
                if (evt) begin
                    m_state = S_PUNCH; m_left = NPUNCH;
                end else if (u) begin
                    m_state = S_JUMP; m_air = 0;
                    air_step(l, r, 1'b0);
                end else if (d) m_state = S_CROUCH;
                else if (l && !r) begin m_state = S_WALK_L; m_x = drift(l, r, m_x); end
                else if (r && !l) begin m_state = S_WALK_R; m_x = drift(l, r, m_x); end
                else m_state = S_STAND;
            end
            S_PUNCH: begin
                m_left--;
                if (m_left == 0) m_state = S_STAND;
            end
            default: air_step(l, r, evt);
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.sprite = m_state; e.x = m_x; e.y = m_y;
        e.atk = (m_state == S_PUNCH || m_state == S_JUMP_ATK) ? 1 : 0;
        return e;
    endfunction

    task automatic tick(bit l, bit r, bit u, bit d, bit p, bit dd);
        @(negedge vga_clk);
        bus.key_left = l; bus.key_right = r; bus.key_up = u;
        bus.key_down = d; bus.key_punch = p; bus.dead = dd;
        bus.frame_tick = 1'b1;
        model_step(l, r, u, d, p, dd);
        q.push_back(model_out());
        @(negedge vga_clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        Reset = 1'b1;
        repeat (2) @(negedge vga_clk);
        Reset = 1'b0;
        model_reset();
    endtask

    // Monitor: the DUT presents a new pose one clock after every frame_tick.
    initial begin
        exp_t e;
        forever begin
            @(posedge vga_clk);
            if (bus.frame_tick === 1'b1 && Reset === 1'b0) begin
                @(negedge vga_clk);
                n_ticks++;
                if (q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL sb_underflow: got 0 queued expected at least 1");
                end else begin
                    e = q.pop_front();
                    $display("tick %0d sprite=%0d x=%0d y=%0d atk=%0d (exp %0d %0d %0d %0d)",
                             n_ticks, bus.sprite, bus.AkumaX, bus.AkumaY, bus.attack_active,
                             e.sprite, e.x, e.y, e.atk);
                    check("sprite", int'(bus.sprite), e.sprite);
                    check("AkumaX", int'(bus.AkumaX), e.x);
                    check("AkumaY", int'(bus.AkumaY), e.y);
                    check("attack_active", int'(bus.attack_active), e.atk);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, miny, land, guard;
        int xs[5];
        exp_t e;
        xs = '{2, 0, 0, 0, 0};
        Reset = 1'b1;
        bus.frame_tick = 0; bus.key_left = 0; bus.key_right = 0; bus.key_up = 0;
        bus.key_down = 0; bus.key_punch = 0; bus.dead = 0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        Reset = 1'b0;
        #1;
        check("rst_sprite", int'(bus.sprite), 0);
        check("rst_x", int'(bus.AkumaX), 100);
        check("rst_y", int'(bus.AkumaY), 300);
        check("rst_atk", int'(bus.attack_active), 0);

        // Walk right 10 frames, then release.
        repeat (10) tick(0, 1, 0, 0, 0, 0);
        #1;
        check("walk_r_sprite", int'(bus.sprite), 5);
        check("walk_r_x", int'(bus.AkumaX), 120);
        check("walk_r_y", int'(bus.AkumaY), 300);
        tick(0, 0, 0, 0, 0, 0);
        #1;
        check("release_sprite", int'(bus.sprite), 0);

        // Left clamp at X_MIN.
        guard = 0;
        while (m_x > 4 && guard < 100) begin tick(1, 0, 0, 0, 0, 0); guard++; end
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            #1;
            check("left_clamp_x", int'(bus.AkumaX), xs[i]);
        end
        tick(1, 1, 0, 0, 0, 0);
        #1;
        check("lr_both_sprite", int'(bus.sprite), 0);
        check("lr_both_x", int'(bus.AkumaX), 0);

        // Held punch: exactly one attack window.
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 0, 0, 1, 0);
            #1;
            if (bus.sprite == 3'd1 && bus.attack_active) cnt++;
        end
        check("punch_frames", cnt, 12);
        check("punch_end_sprite", int'(bus.sprite), 0);
        tick(0, 0, 0, 0, 0, 0);

        // Jump with air attack on frame 5.
        miny = 999; land = 0; cnt = 0;
        for (int t = 1; t <= 30; t++) begin
            tick(0, 0, t == 1, 0, t == 5, 0);
            #1;
            if (t == 1) begin
                check("jump_first_y", int'(bus.AkumaY), 288);
                check("jump_sprite", int'(bus.sprite), 2);
            end
            if (t == 17) check("jatk_return", int'(bus.sprite), 2);
            if (int'(bus.AkumaY) < miny) miny = int'(bus.AkumaY);
            if (bus.sprite == 3'd7) cnt++;
            if (land == 0 && bus.AkumaY == 10'd300 && bus.sprite == 3'd0) land = t;
        end
        check("jump_peak_y", miny, 222);
        check("jump_land_tick", land, 25);
        check("jatk_frames", cnt, 12);

        // Death mid-jump freezes everything.
        tick(0, 0, 1, 0, 0, 0);
        guard = 0;
        while (m_y != 250 && guard < 10) begin tick(0, 0, 0, 0, 0, 0); guard++; end
        tick(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            tick($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        #1;
        check("death_sprite", int'(bus.sprite), 6);
        check("death_y", int'(bus.AkumaY), 250);

        // Asynchronous reset mid-jump.
        do_reset();
        repeat (3) tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        @(negedge vga_clk);
        #3 Reset = 1'b1;
        #1;
        check("async_rst_x", int'(bus.AkumaX), 100);
        check("async_rst_y", int'(bus.AkumaY), 300);
        check("async_rst_sprite", int'(bus.sprite), 0);
        check("async_rst_atk", int'(bus.attack_active), 0);
        model_reset();
        repeat (2) @(negedge vga_clk);
        Reset = 1'b0;

        // Inputs toggling with no frame_tick must not move anything.
        repeat (2) tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge vga_clk);
            bus.key_left = 1'($urandom); bus.key_right = 1'($urandom);
            bus.key_up = 1'($urandom); bus.key_down = 1'($urandom);
            bus.key_punch = 1'($urandom); bus.dead = 1'($urandom);
        end
        #1;
        e = model_out();
        check("idle_sprite", int'(bus.sprite), e.sprite);
        check("idle_x", int'(bus.AkumaX), e.x);
        check("idle_y", int'(bus.AkumaY), e.y);
        check("idle_atk", int'(bus.attack_active), e.atk);
        tick(0, 0, 0, 0, 1, 0);

        // Randomized play.
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge vga_clk);
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, 1'b0);
        end

        repeat (3) @(negedge vga_clk);
        check("sb_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
